// File: rtl/counter_updown.sv
// counter_updown: parametrised synchronous up/down counter with load,
// selectable end-of-count behaviour (wrap / saturate / one-shot), a
// registered Gray-coded copy of the count, and terminal-count, sticky
// overflow and one-shot done flags.
`timescale 1ns/1ps

module counter_updown #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter int              MODE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    // End-of-count behaviours selectable through MODE
    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;
    localparam int MODE_ONESHOT  = 2;

    // Highest legal count; arithmetic is modulo MODULUS, not 2**WIDTH
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] terminal;
    logic             at_terminal;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;
    logic             next_ovf;
    logic             next_done;

    // The terminal value follows the direction currently requested
    assign terminal     = up ? MAX_COUNT : '0;
    assign at_terminal  = (count == terminal);
    assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

    // tc is high exactly in the cycle whose rising edge performs an end-of-count event
    assign tc = en & ~load & ~done & at_terminal;

    // Next-state selection: load beats enable, and a finished one-shot ignores enable
    always_comb begin
        next_count = count;
        next_ovf   = ovf;
        next_done  = done;
        if (load) begin
            next_count = load_clamped;
            next_ovf   = 1'b0;
            next_done  = 1'b0;
        end else if (en && !done) begin
            if (at_terminal) begin
                next_ovf = 1'b1;
                if (MODE == MODE_WRAP) begin
                    next_count = up ? '0 : MAX_COUNT;
                end else if (MODE == MODE_ONESHOT) begin
                    next_done = 1'b1;
                end else if (MODE == MODE_SATURATE) begin
                    next_count = count;
                end
            end else if (up) begin
                next_count = count + ONE;
            end else begin
                next_count = count - ONE;
            end
        end
    end

    // State registers; gray is built from next_count so it stays aligned with count
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            gray  <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= next_count;
            gray  <= next_count ^ (next_count >> 1);
            ovf   <= next_ovf;
            done  <= next_done;
        end
    end

endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: directed checks of counter_updown in four configurations
// (2-bit wrap, mod-10 wrap, mod-10 saturate, mod-10 one-shot) followed by a
// randomised direction/enable/load run against a small reference model.
`timescale 1ns/1ps

module tb_counter_updown;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       en0, up0, load0;
    logic [1:0] lv0, cnt0, gray0;
    logic       tc0, ovf0, done0;

    logic       en1, up1, load1;
    logic [3:0] lv1, cnt1, gray1;
    logic       tc1, ovf1, done1;

    logic       en2, up2, load2;
    logic [3:0] lv2, cnt2, gray2;
    logic       tc2, ovf2, done2;

    logic       en3, up3, load3;
    logic [3:0] lv3, cnt3, gray3;
    logic       tc3, ovf3, done3;

    int checks = 0;
    int errors = 0;

    logic       rE, rU, rL, expTc;
    logic [3:0] rV, m, mGray;
    logic       mo;

    counter_updown #(.WIDTH(2), .MODULUS(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .up(up0), .load(load0), .load_value(lv0),
        .count(cnt0), .gray(gray0), .tc(tc0), .ovf(ovf0), .done(done0));

    counter_updown #(.WIDTH(4), .MODULUS(10), .MODE(0)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .up(up1), .load(load1), .load_value(lv1),
        .count(cnt1), .gray(gray1), .tc(tc1), .ovf(ovf1), .done(done1));

    counter_updown #(.WIDTH(4), .MODULUS(10), .MODE(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .up(up2), .load(load2), .load_value(lv2),
        .count(cnt2), .gray(gray2), .tc(tc2), .ovf(ovf2), .done(done2));

    counter_updown #(.WIDTH(4), .MODULUS(10), .MODE(2)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .up(up3), .load(load3), .load_value(lv3),
        .count(cnt3), .gray(gray3), .tc(tc3), .ovf(ovf3), .done(done3));

    always #5 clk = ~clk;

    // Drive one counter's inputs; every other counter idles with en=0, load=0
    task automatic applyStimulus(input int d, input logic e, input logic u,
                                 input logic l, input logic [3:0] v);
        en0 = 1'b0; load0 = 1'b0; up0 = 1'b0; lv0 = 2'd0;
        en1 = 1'b0; load1 = 1'b0; up1 = 1'b0; lv1 = 4'd0;
        en2 = 1'b0; load2 = 1'b0; up2 = 1'b0; lv2 = 4'd0;
        en3 = 1'b0; load3 = 1'b0; up3 = 1'b0; lv3 = 4'd0;
        case (d)
            0: begin en0 = e; up0 = u; load0 = l; lv0 = v[1:0]; end
            1: begin en1 = e; up1 = u; load1 = l; lv1 = v; end
            2: begin en2 = e; up2 = u; load2 = l; lv2 = v; end
            3: begin en3 = e; up3 = u; load3 = l; lv3 = v; end
            default: ;
        endcase
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int c0[5]  = '{1, 2, 3, 0, 1};
        int g0[5]  = '{1, 3, 2, 0, 1};
        int t0[5]  = '{0, 0, 0, 1, 0};
        int o0[5]  = '{0, 0, 0, 1, 1};
        int c1[4]  = '{1, 0, 9, 8};
        int g1[4]  = '{1, 0, 13, 12};
        int t1[4]  = '{0, 0, 1, 0};
        int o1[4]  = '{0, 0, 1, 1};
        int c2[5]  = '{8, 9, 9, 9, 9};
        int t2[5]  = '{0, 0, 1, 1, 1};
        int o2[5]  = '{0, 0, 1, 1, 1};
        int t3[4]  = '{0, 1, 0, 0};
        int d3[4]  = '{0, 1, 1, 1};

        // Reset all counters
        rst = 1'b1;
        applyStimulus(9, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
        checkOutput("rst_gray0", 32'(gray0), 32'd0);
        checkOutput("rst_ovf0", 32'(ovf0), 32'd0);
        checkOutput("rst_cnt3", 32'(cnt3), 32'd0);
        checkOutput("rst_done3", 32'(done3), 32'd0);
        rst = 1'b0;

        // 2-bit natural wrap counting up
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput("w2_tc", 32'(tc0), 32'(t0[i]));
            tick();
            checkOutput("w2_cnt", 32'(cnt0), 32'(c0[i]));
            checkOutput("w2_gray", 32'(gray0), 32'(g0[i]));
            checkOutput("w2_ovf", 32'(ovf0), 32'(o0[i]));
        end

        // Mod-10 wrap: load 2 then count down through 0 -> 9
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd2);
        tick();
        checkOutput("m10_load", 32'(cnt1), 32'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd0);
            checkOutput("m10_tc", 32'(tc1), 32'(t1[i]));
            tick();
            checkOutput("m10_cnt", 32'(cnt1), 32'(c1[i]));
            checkOutput("m10_gray", 32'(gray1), 32'(g1[i]));
            checkOutput("m10_ovf", 32'(ovf1), 32'(o1[i]));
        end

        // Saturate: load 7, count up into 9 and hold, then reverse
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 4'd7);
        tick();
        checkOutput("sat_load", 32'(cnt2), 32'd7);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput("sat_tc", 32'(tc2), 32'(t2[i]));
            tick();
            checkOutput("sat_cnt", 32'(cnt2), 32'(c2[i]));
            checkOutput("sat_ovf", 32'(ovf2), 32'(o2[i]));
        end
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("sat_down_tc", 32'(tc2), 32'd0);
        tick();
        checkOutput("sat_down_cnt", 32'(cnt2), 32'd8);
        checkOutput("sat_down_ovf", 32'(ovf2), 32'd1);
        checkOutput("sat_done", 32'(done2), 32'd0);

        // One-shot: load 8, run into the end and stay finished, then reload 0
        applyStimulus(3, 1'b0, 1'b0, 1'b1, 4'd8);
        tick();
        checkOutput("os_load", 32'(cnt3), 32'd8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput("os_tc", 32'(tc3), 32'(t3[i]));
            tick();
            checkOutput("os_cnt", 32'(cnt3), 32'd9);
            checkOutput("os_done", 32'(done3), 32'(d3[i]));
            checkOutput("os_ovf", 32'(ovf3), 32'(d3[i]));
        end
        applyStimulus(3, 1'b1, 1'b1, 1'b1, 4'd0);
        checkOutput("os_reload_tc", 32'(tc3), 32'd0);
        tick();
        checkOutput("os_reload_cnt", 32'(cnt3), 32'd0);
        checkOutput("os_reload_done", 32'(done3), 32'd0);
        checkOutput("os_reload_ovf", 32'(ovf3), 32'd0);

        // Clamp: load 13 into a mod-10 counter (also clears the earlier ovf)
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd13);
        tick();
        checkOutput("clamp_cnt", 32'(cnt1), 32'd9);
        checkOutput("clamp_gray", 32'(gray1), 32'd13);
        checkOutput("clamp_ovf", 32'(ovf1), 32'd0);

        // Load and enable together at the terminal value: load wins
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 4'd9);
        checkOutput("ld_en_tc", 32'(tc1), 32'd0);
        tick();
        checkOutput("ld_en_cnt", 32'(cnt1), 32'd9);
        checkOutput("ld_en_ovf", 32'(ovf1), 32'd0);

        // Wrap 9 -> 0 to set ovf, count on, then reset together with load
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("pre_rst_cnt", 32'(cnt1), 32'd0);
        checkOutput("pre_rst_ovf", 32'(ovf1), 32'd1);
        tick();
        checkOutput("pre_rst_cnt2", 32'(cnt1), 32'd1);
        rst = 1'b1;
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 4'd7);
        tick();
        checkOutput("rst_ld_cnt", 32'(cnt1), 32'd0);
        checkOutput("rst_ld_gray", 32'(gray1), 32'd0);
        checkOutput("rst_ld_ovf", 32'(ovf1), 32'd0);
        checkOutput("rst_ld_done", 32'(done1), 32'd0);
        rst = 1'b0;

        // Randomised direction / enable / occasional load against a reference model
        m  = 4'd0;
        mo = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            rE = 1'($urandom_range(0, 1));
            rU = 1'($urandom_range(0, 1));
            rL = ($urandom_range(0, 15) == 0);
            rV = 4'($urandom_range(0, 15));
            applyStimulus(1, rE, rU, rL, rV);
            expTc = rE & ~rL & (m == (rU ? 4'd9 : 4'd0));
            checkOutput("rand_tc", 32'(tc1), 32'(expTc));
            if (rL) begin
                m  = (rV > 4'd9) ? 4'd9 : rV;
                mo = 1'b0;
            end else if (rE) begin
                if (rU) begin
                    if (m == 4'd9) begin m = 4'd0; mo = 1'b1; end
                    else m = m + 4'd1;
                end else begin
                    if (m == 4'd0) begin m = 4'd9; mo = 1'b1; end
                    else m = m - 4'd1;
                end
            end
            mGray = m ^ (m >> 1);
            tick();
            checkOutput("rand_cnt", 32'(cnt1), 32'(m));
            checkOutput("rand_gray", 32'(gray1), 32'(mGray));
            checkOutput("rand_ovf", 32'(ovf1), 32'(mo));
        end
        checkOutput("rand_done", 32'(done1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_updown.md
# counter_updown

Parametrised synchronous up/down counter for lab benches and small datapaths. It replaces fixed 2-bit free-running stimulus counters with a configurable width, modulus, direction, load and end-of-count mode. It provides a binary count, a registered Gray-coded count and terminal-count/overflow/done flags. These drive DUT inputs in testbenches and act as a timebase in synthesisable designs.

## Interface

- WIDTH, 4: count width in bits, 1..32.
- MODULUS, 2**WIDTH: number of count states, 2..2**WIDTH; the counting range is 0..MODULUS-1.
- MODE, 0: end-of-count behaviour. 0 = wrap, 1 = saturate, 2 = one-shot.

Ports:

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled each enabled cycle.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value for load.
- count  out  WIDTH  registered binary count.
- gray  out  WIDTH  registered Gray code of count, cycle-aligned with count.
- tc  out  1  combinational terminal-count indicator.
- ovf  out  1  registered sticky end-of-count flag.
- done  out  1  registered one-shot completion flag; MODE=2 only, otherwise 0.

## Operation

- Terminal value: MODULUS-1 when up=1, 0 when up=0.
- Per-edge priority: rst > load > en > hold.
- rst=1:
  - count=0, gray=0, ovf=0, done=0.
  - Aborts any operation in progress, including mid-load and mid-count.
- load=1 (rst=0):
  - count = load_value, clamped to MODULUS-1 if load_value >= MODULUS.
  - ovf=0, done=0.
  - en is ignored that cycle.
- en=1, load=0, done=0, count not at terminal: count ±1 per up.
- en=1, load=0, done=0, count at terminal (the "end-of-count event"):
  - MODE 0: up → 0, down → MODULUS-1. ovf set.
  - MODE 1: count holds at terminal. ovf set.
  - MODE 2: count holds at terminal. done set. ovf set.
- done=1: en is ignored and count holds until load or rst.
- Direction may change on any cycle. The terminal value follows the current up, so at count=0 with up=1 there is no event.
- Arithmetic is modulo MODULUS, not 2**WIDTH. When MODULUS=2**WIDTH, natural binary wrap results.
- gray is registered from the next count value: gray = next ^ (next >> 1). It therefore always equals the Gray code of count.
- tc = en & ~load & ~done & (count == terminal value). It is high in exactly the cycle whose rising edge performs an end-of-count event.
- ovf and done are sticky; only load or rst clears them.

## Timing

- Latency:
  - count and gray update on the edge where the controlling input is sampled; one cycle from en/load/up to the new count.
  - ovf and done assert on the same edge as the end-of-count event.
- tc is combinational from count, en, load, up and done; it has no register delay. Consumers sample it at the next edge.
- After rst is released, the first counting edge is the first edge with en=1.
- An out-of-range count value is impossible after reset; load clamps.
- Asserting load and rst together: reset wins.
- Asserting load and en at the terminal value together: load wins, and no ovf or done is set.

## Test plan

- WIDTH=2, MODULUS=4, MODE=0:
  - Stimulus: reset, then en=1, up=1 for 5 cycles.
  - Required response: count 0,1,2,3,0,1; gray 0,1,3,2,0,1; tc high only while count=3; ovf=1 from the wrap onward.
- WIDTH=4, MODULUS=10, MODE=0:
  - Stimulus: load 2, then count down 4 cycles.
  - Required response: count 2,1,0,9,8; tc high while count=0; ovf set at 0→9.
- WIDTH=4, MODULUS=10, MODE=1:
  - Stimulus: load 7, then count up 5 cycles.
  - Required response: count 7,8,9,9,9,9; ovf=1 after the first enabled cycle at 9; then up=0 gives 8.
- WIDTH=4, MODULUS=10, MODE=2:
  - Stimulus: load 8, en=1 up=1 for 4 cycles, then load 0.
  - Required response: count 8,9,9,9; done=1 after the event and en ignored; the load gives count=0, done=0, ovf=0.
- WIDTH=4, MODULUS=10, clamp and priority:
  - Stimulus: load 13.
  - Required response: count=9.
  - Stimulus: load=1 and en=1 at count=9 with up=1.
  - Required response: no ovf.
  - Stimulus: assert rst together with load on a mid-count cycle.
  - Required response: count=0, gray=0, all flags 0.
- Randomised direction/en toggling for 1000 cycles, MODE=0:
  - Required response: count matches a reference model; gray always equals count ^ (count >> 1); tc matches the event definition.
